bj_round_ctrl: RTL
==================

# bj_round_ctrl

Round sequencer for the blackjack datapath: deals the opening hands, runs the player turn from debounced hit/stay pulses, and plays the dealer hand automatically. It scores and resolves each round and keeps win/push/loss tallies. Cards come from an external random card source through a request/valid handshake. The block sits between the debounced button inputs and the display/score logic.

## Interface
- `DEALER_STAND`, 17, dealer stops drawing at or above this total.
- `CNT_W`, 16, width of the tally counters.
- `clk_200Hz` in 1: system clock.
- `rst` in 1: synchronous, active-high reset.
- `start` in 1: begin-round pulse.
- `hit` in 1: debounced single-cycle hit pulse.
- `stay` in 1: debounced single-cycle stay pulse.
- `card_req` out 1: request one card from the card source.
- `card_valid` in 1: card source presents `card_idx`.
- `card_idx` in 4: card rank; 0=A, 1..9 = ranks 2..10, 10..12 = J/Q/K.
- `player_total` out 5: player hand value after ace correction.
- `dealer_total` out 5: dealer hand value after ace correction.
- `player_turn` out 1: high while in PLAYER.
- `round_done` out 1: one-cycle pulse on entering DONE.
- `result` out 2: outcome code; 00 none, 01 win, 10 push, 11 loss.
- `wins`, `pushes`, `losses` out CNT_W: round tallies.

## Operation
- States: IDLE, DEAL_P1, DEAL_D1, DEAL_P2, DEAL_D2, PLAYER, P_DRAW, DEALER, D_DRAW, RESOLVE, DONE.
- IDLE/DONE + `start`:
  - clears totals, soft-ace counts and `result`;
  - goes to DEAL_P1.
  - `start` in any other state is ignored.
- Deal and draw states assert `card_req` until the card is accepted (`card_req && card_valid`).
  - On accept the card is added to the target hand and the FSM advances.
  - `card_valid` without `card_req` is ignored.
- Card value: idx 0 = 11 and increments that hand's soft-ace count; idx 1..9 = idx+1; idx 10..15 = 10.
- Ace correction:
  - sum is formed at 6 bits;
  - if the sum exceeds 21 and the soft-ace count is nonzero, subtract 10 and decrement the count;
  - only one correction per card.
  - The result always fits 5 bits.
- Deal order: P, D, P, D, then PLAYER.
- PLAYER:
  - total 21 goes to DEALER immediately.
  - `stay` goes to DEALER.
  - `hit` goes to P_DRAW; after the draw, total >21 goes to RESOLVE, else back to PLAYER.
  - `hit` and `stay` in the same cycle: `stay` wins.
  - `hit`/`stay` outside PLAYER are ignored.
- DEALER:
  - `dealer_total` < `DEALER_STAND` goes to D_DRAW, which returns to DEALER after the draw;
  - otherwise goes to RESOLVE.
- RESOLVE, in priority order:
  - player >21: loss;
  - dealer >21: win;
  - equal totals: push;
  - player > dealer: win;
  - otherwise loss.
  - Exactly one tally increments per round; tallies saturate at all-ones.
- DONE: holds totals and `result` until the next `start`.

## Timing
- Reset values:
  - state IDLE;
  - `card_req`, `player_turn`, `round_done` = 0;
  - totals = 0; `result` = 00; all tallies = 0.
- Reset mid-round aborts the round with no tally update. A pending `card_req` drops on the next edge.
- `start` sampled at edge N: `card_req` is high from edge N+1.
- Card accepted at edge M:
  - total updated at edge M;
  - `card_req` low for at least one cycle, M+1;
  - the next request is asserted from M+2.
- `card_valid` may arrive in the same cycle `card_req` rises; zero-wait acceptance is legal.
- PLAYER reacts to `hit`/`stay` in the cycle sampled.
- RESOLVE lasts one cycle. Tally, `result` and `round_done` update together on the edge entering DONE.

## Configuration
- `BJ_SOFT17_HIT_EN` defined: the dealer also draws when `dealer_total` == 17 and the dealer soft-ace count is nonzero (hits soft 17).
- Undefined: the dealer stands on any total ≥ `DEALER_STAND`.

## Test plan
- Deal idx 9,5,9,6 (P=20, D=13); `stay`; dealer draws idx 4 (D=18) → `result`=01, `wins`=1, `round_done` one cycle.
- Deal idx 0,9,0,8 (P=A+A=12, D=19); `hit`, draw idx 8 → P=21, auto-exit to DEALER, D stands → `result`=01.
- Deal 9,9,5,9 (P=16, D=20); `hit`, draw 9 → P=26 → RESOLVE without dealer draw, `result`=11, `losses`=1.
- Deal 9,9,7,7 (P=18, D=18); `stay` → `result`=10, `pushes`=1.
- Dealer A+6 (soft 17): with `BJ_SOFT17_HIT_EN` one extra `card_req` is issued; without it there is none.
- Assert `rst` while `card_req` is high in P_DRAW → next cycle state IDLE, all outputs zero; `hit`+`stay` same cycle in PLAYER → DEALER, no draw.

Source files
------------

// File: rtl/bj_round_ctrl_if.sv
// Card source handshake for the blackjack round sequencer.
// The sequencer is master (raises card_req); the random card source is slave.
interface bj_round_ctrl_if;
  logic       card_req;
  logic       card_valid;
  logic [3:0] card_idx;

  modport master (
    output card_req,
    input  card_valid,
    input  card_idx
  );

  modport slave (
    input  card_req,
    output card_valid,
    output card_idx
  );
endinterface

// File: rtl/bj_round_ctrl.sv
// Blackjack round sequencer: deal, player turn, dealer play, resolve, tallies.
// Build option BJ_SOFT17_HIT_EN: dealer also hits a soft 17.
module bj_round_ctrl #(
  parameter int DEALER_STAND = 17,
  parameter int CNT_W        = 16
) (
  input  logic             clk_200Hz,
  input  logic             rst,
  input  logic             start,
  input  logic             hit,
  input  logic             stay,
  bj_round_ctrl_if.master  card,
  output logic [4:0]       player_total,
  output logic [4:0]       dealer_total,
  output logic             player_turn,
  output logic             round_done,
  output logic [1:0]       result,
  output logic [CNT_W-1:0] wins,
  output logic [CNT_W-1:0] pushes,
  output logic [CNT_W-1:0] losses
);

  typedef enum logic [3:0] {
    IDLE, DEAL_P1, DEAL_D1, DEAL_P2, DEAL_D2,
    PLAYER, P_DRAW, DEALER, D_DRAW, RESOLVE, DONE
  } state_t;

  localparam logic [4:0] LP_STAND = 5'(DEALER_STAND);
  localparam logic [1:0] RES_WIN  = 2'b01;
  localparam logic [1:0] RES_PUSH = 2'b10;
  localparam logic [1:0] RES_LOSS = 2'b11;

  state_t           r_state;
  state_t           w_next;
  logic [4:0]       r_ptot;
  logic [4:0]       r_dtot;
  logic [3:0]       r_psoft;
  logic [3:0]       r_dsoft;
  logic             r_gap;
  logic             r_done;
  logic [1:0]       r_result;
  logic [CNT_W-1:0] r_wins;
  logic [CNT_W-1:0] r_pushes;
  logic [CNT_W-1:0] r_losses;

  logic             w_req;
  logic             w_turn;
  logic             w_accept;
  logic             w_tgt_p;
  logic             w_ace;
  logic [3:0]       w_val;
  logic [4:0]       w_tot;
  logic [3:0]       w_soft;
  logic [5:0]       w_sum;
  logic [3:0]       w_soft_inc;
  logic [4:0]       w_new_tot;
  logic [3:0]       w_new_soft;
  logic             w_dhit;
  logic [1:0]       w_res;
  logic             w_start_ok;

  assign w_accept   = w_req && card.card_valid;
  assign w_start_ok = (r_state == IDLE || r_state == DONE) && start;
  assign w_tgt_p    = (r_state == DEAL_P1) || (r_state == DEAL_P2)
                   || (r_state == P_DRAW);
  assign w_ace      = (card.card_idx == 4'd0);

  // Card rank to point value; an ace counts 11 until corrected.
  always_comb begin
    w_val = 4'd10;
    unique case (1'b1)
      (card.card_idx == 4'd0): w_val = 4'd11;
      (card.card_idx >= 4'd1 && card.card_idx <= 4'd9):
        w_val = card.card_idx + 4'd1;
      (card.card_idx >= 4'd10): w_val = 4'd10;
    endcase
  end

  // Add the incoming card to its hand with at most one soft-ace correction.
  always_comb begin
    w_tot      = w_tgt_p ? r_ptot  : r_dtot;
    w_soft     = w_tgt_p ? r_psoft : r_dsoft;
    w_sum      = {1'b0, w_tot} + {2'b00, w_val};
    w_soft_inc = w_soft + {3'b000, w_ace};
    w_new_tot  = w_sum[4:0];
    w_new_soft = w_soft_inc;
    if (w_sum > 6'd21 && w_soft_inc != 4'd0) begin
      w_new_tot  = 5'(w_sum - 6'd10);
      w_new_soft = w_soft_inc - 4'd1;
    end
  end

  // Dealer draw decision, optionally hitting a soft 17.
  always_comb begin
    w_dhit = (r_dtot < LP_STAND);
`ifdef BJ_SOFT17_HIT_EN
    if (r_dtot == 5'd17 && r_dsoft != 4'd0) w_dhit = 1'b1;
`endif
  end

  // Outcome ranking: player bust, dealer bust, tie, higher total.
  always_comb begin
    w_res = RES_LOSS;
    unique case (1'b1)
      (r_ptot > 5'd21): w_res = RES_LOSS;
      (r_ptot <= 5'd21 && r_dtot > 5'd21): w_res = RES_WIN;
      (r_ptot <= 5'd21 && r_dtot <= 5'd21 && r_ptot == r_dtot):
        w_res = RES_PUSH;
      (r_ptot <= 5'd21 && r_dtot <= 5'd21 && r_ptot > r_dtot):
        w_res = RES_WIN;
      (r_ptot <= 5'd21 && r_dtot <= 5'd21 && r_ptot < r_dtot):
        w_res = RES_LOSS;
    endcase
  end

  // State register.
  always_ff @(posedge clk_200Hz) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next;
  end

  // Next-state logic; stay beats hit, a 21 leaves the player turn at once.
  always_comb begin
    w_next = r_state;
    unique case (r_state)
      IDLE, DONE: if (start) w_next = DEAL_P1;
      DEAL_P1:    if (w_accept) w_next = DEAL_D1;
      DEAL_D1:    if (w_accept) w_next = DEAL_P2;
      DEAL_P2:    if (w_accept) w_next = DEAL_D2;
      DEAL_D2:    if (w_accept) w_next = PLAYER;
      PLAYER: begin
        if (r_ptot == 5'd21) w_next = DEALER;
        else if (stay)       w_next = DEALER;
        else if (hit)        w_next = P_DRAW;
      end
      P_DRAW: if (w_accept)
        w_next = (w_new_tot > 5'd21) ? RESOLVE : PLAYER;
      DEALER:  w_next = w_dhit ? D_DRAW : RESOLVE;
      D_DRAW:  if (w_accept) w_next = DEALER;
      RESOLVE: w_next = DONE;
      default: w_next = IDLE;
    endcase
  end

  // Moore outputs; a request rests one cycle after each accepted card.
  always_comb begin
    w_req  = 1'b0;
    w_turn = 1'b0;
    unique case (r_state)
      DEAL_P1, DEAL_D1, DEAL_P2, DEAL_D2, P_DRAW, D_DRAW:
        w_req = !r_gap;
      PLAYER:  w_turn = 1'b1;
      default: ;
    endcase
  end

  // Hand totals, outcome and tallies.
  always_ff @(posedge clk_200Hz) begin
    if (rst) begin
      r_ptot   <= '0;
      r_dtot   <= '0;
      r_psoft  <= '0;
      r_dsoft  <= '0;
      r_gap    <= 1'b0;
      r_done   <= 1'b0;
      r_result <= '0;
      r_wins   <= '0;
      r_pushes <= '0;
      r_losses <= '0;
    end else begin
      r_gap  <= w_accept;
      r_done <= 1'b0;
      if (w_start_ok) begin
        r_ptot   <= '0;
        r_dtot   <= '0;
        r_psoft  <= '0;
        r_dsoft  <= '0;
        r_result <= '0;
      end
      if (w_accept) begin
        if (w_tgt_p) begin
          r_ptot  <= w_new_tot;
          r_psoft <= w_new_soft;
        end else begin
          r_dtot  <= w_new_tot;
          r_dsoft <= w_new_soft;
        end
      end
      if (r_state == RESOLVE) begin
        r_result <= w_res;
        r_done   <= 1'b1;
        unique case (1'b1)
          (w_res == RES_WIN):
            if (r_wins != '1) r_wins <= r_wins + CNT_W'(1);
          (w_res == RES_PUSH):
            if (r_pushes != '1) r_pushes <= r_pushes + CNT_W'(1);
          (w_res == RES_LOSS):
            if (r_losses != '1) r_losses <= r_losses + CNT_W'(1);
          default: ;
        endcase
      end
    end
  end

  assign card.card_req = w_req;
  assign player_turn   = w_turn;
  assign round_done    = r_done;
  assign player_total  = r_ptot;
  assign dealer_total  = r_dtot;
  assign result        = r_result;
  assign wins          = r_wins;
  assign pushes        = r_pushes;
  assign losses        = r_losses;

endmodule
